prio_encoder_rr: RTL

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready handshake on both sides. It supports fixed-priority and round-robin arbitration modes and flags zero-hot and multi-hot inputs. It is the generalised successor to the fixed 4-to-2 encoder and is used wherever a request vector must become a granted index for downstream logic. The output stage is a single-entry register that sustains one encode per cycle under back-pressure.

---
 rtl/prio_encoder_rr.sv | 54 +++++
 1 files changed

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered N-to-log2(N) priority encoder, fixed or round-robin, valid/ready on both sides
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         none,
  output logic         multi,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [W-1:0] ptr, gidx;
  logic acc, pop, any, many;
  assign out_valid = state == FULL;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign any = |req;
  assign many = |(req & (req - N'(1)));
  // Scan offsets from farthest to nearest so the first set bit at or above ptr wins; W-bit sums wrap modulo N.
  always_comb begin
    gidx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[W'(ptr + W'(k))]) gidx = W'(ptr + W'(k));
  end
  always_comb state_nxt = acc ? FULL : pop ? EMPTY : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= EMPTY;
      idx    <= '0;
      onehot <= '0;
      none   <= 1'b0;
      multi  <= 1'b0;
      ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        idx    <= any ? gidx : '0;
        onehot <= any ? N'(1) << gidx : '0;
        none   <= !any;
        multi  <= many;
        if (MODE == 1 && any) ptr <= gidx + W'(1);
      end
    end
endmodule
